pos_fetch_ctrl: RTL and testbench

Sequences reads of the six object-position words (mx, my, p1x, p1y, p2x, p2y) from the read-only VGA port (port A) of the shared memory, once per frame. Words are captured into shadow registers. All six are committed atomically to output registers, so the VGA renderer never sees a half-updated set of positions. Replaces the free-running vga_counter/mux8/flopenr chain in the top level and is triggered by the VGA block's frame_start pulse.

---
 rtl/pos_fetch_ctrl_if.sv | 11 +
 rtl/pos_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_pos_fetch_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pos_fetch_ctrl_if.sv
// Read-only memory port A as seen by the position fetch controller.
// The master drives the address and the slave (the memory) returns data RD_LAT clocks later.
interface pos_fetch_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] addr_a;
    logic [WIDTH-1:0] q_a;

    modport master (output addr_a, input q_a);
    modport slave  (input addr_a, output q_a);
endinterface

// File: rtl/pos_fetch_ctrl.sv
// Once per frame, fetches the six object-position words from memory port A into shadow
// registers, then commits all six to the outputs in one edge so the renderer never sees a partial update.
module pos_fetch_ctrl #(
    parameter int          WIDTH  = 16,
    parameter int          RD_LAT = 1,
    parameter int unsigned MXP    = 6000,
    parameter int unsigned MYP    = 6004,
    parameter int unsigned P1XP   = 6008,
    parameter int unsigned P1YP   = 6012,
    parameter int unsigned P2XP   = 6016,
    parameter int unsigned P2YP   = 6020
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    pos_fetch_ctrl_if.master mem,
    output logic [WIDTH-1:0] mx,
    output logic [WIDTH-1:0] my,
    output logic [WIDTH-1:0] p1x,
    output logic [WIDTH-1:0] p1y,
    output logic [WIDTH-1:0] p2x,
    output logic [WIDTH-1:0] p2y,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       drain_q, drain_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [2:0]       pi_q [RD_LAT];
    logic [2:0]       pi_d [RD_LAT];
    logic [WIDTH-1:0] shadow_q [6];
    logic [WIDTH-1:0] shadow_d [6];
    logic [WIDTH-1:0] pos_q [6];
    logic [WIDTH-1:0] pos_d [6];
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] addr_c;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        shadow_d  = shadow_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        overrun_d = overrun_q | (frame_start && state_q != IDLE);
        addr_c    = WIDTH'(MXP);

        // idx pipeline: stage RD_LAT-1 names the shadow that the current q_a belongs to
        pv_d[0] = (state_q == ISSUE);
        pi_d[0] = idx_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
        if (pv_q[RD_LAT-1]) shadow_d[pi_q[RD_LAT-1]] = mem.q_a;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ISSUE;
                    idx_d   = 3'd0;
                end
            end
            ISSUE: begin
                case (idx_q)
                    3'd0:    addr_c = WIDTH'(MXP);
                    3'd1:    addr_c = WIDTH'(MYP);
                    3'd2:    addr_c = WIDTH'(P1XP);
                    3'd3:    addr_c = WIDTH'(P1YP);
                    3'd4:    addr_c = WIDTH'(P2XP);
                    default: addr_c = WIDTH'(P2YP);
                endcase
                if (idx_q == 3'd5) begin
                    state_d = DRAIN;
                    drain_d = 2'(RD_LAT - 1);
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DRAIN: begin
                addr_c = WIDTH'(P2YP);
                if (drain_q == 2'd0) state_d = COMMIT;
                else                 drain_d = drain_q - 2'd1;
            end
            COMMIT: begin
                addr_c  = WIDTH'(P2YP);
                pos_d   = shadow_q;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            drain_q   <= 2'd0;
            pv_q      <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            // NOTE: shadows are register banks, not RAM, so they are cleared with everything else.
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= '0;
                pos_q[i]    <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) pi_q[i] <= 3'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            pv_q      <= pv_d;
            pi_q      <= pi_d;
            shadow_q  <= shadow_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem.addr_a = addr_c;
    assign mx      = pos_q[0];
    assign my      = pos_q[1];
    assign p1x     = pos_q[2];
    assign p1y     = pos_q[3];
    assign p2x     = pos_q[4];
    assign p2y     = pos_q[5];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_pos_fetch_ctrl.sv
// Directed bench: one controller per read latency, each with a behavioural port-A memory.
module tb_pos_fetch_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic fs1, fs2;
    logic [15:0] mem [6];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pos_fetch_ctrl_if #(.WIDTH(16)) mif1 ();
    pos_fetch_ctrl_if #(.WIDTH(16)) mif2 ();

    logic [15:0] pos1 [6];
    logic [15:0] pos2 [6];
    logic busy1, done1, valid1, ovr1;
    logic busy2, done2, valid2, ovr2;

    pos_fetch_ctrl #(.WIDTH(16), .RD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .frame_start(fs1), .mem(mif1.master),
        .mx(pos1[0]), .my(pos1[1]), .p1x(pos1[2]), .p1y(pos1[3]), .p2x(pos1[4]), .p2y(pos1[5]),
        .busy(busy1), .done(done1), .valid(valid1), .overrun(ovr1)
    );

    pos_fetch_ctrl #(.WIDTH(16), .RD_LAT(2)) u2 (
        .clk(clk), .reset(reset), .frame_start(fs2), .mem(mif2.master),
        .mx(pos2[0]), .my(pos2[1]), .p1x(pos2[2]), .p1y(pos2[3]), .p2x(pos2[4]), .p2y(pos2[5]),
        .busy(busy2), .done(done2), .valid(valid2), .overrun(ovr2)
    );

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (a >= 16'd6000 && a <= 16'd6020 && a[1:0] == 2'b00) return mem[(a - 16'd6000) >> 2];
        return 16'hdead;
    endfunction

    logic [15:0] r2;
    always @(posedge clk) begin
        mif1.q_a <= rd(mif1.addr_a);
        r2       <= rd(mif2.addr_a);
        mif2.q_a <= r2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos1(input string tag, input logic [15:0] mul);
        for (int k = 0; k < 6; k++) check(tag, pos1[k], 16'(mul * (k + 1)));
    endtask

    // Caller asserts fs1 in cycle 0; checks cycles 1..9 (and 10 unless chaining into another fetch).
    task automatic run1(input logic [15:0] old_mul, input logic [15:0] new_mul,
                        input int extra, input bit chain);
        for (int c = 1; c <= 9; c++) begin
            tick();
            fs1 = (c == extra) || (c == 9 && chain);
            if (c <= 6) check($sformatf("addr_c%0d", c), mif1.addr_a, 6000 + 4 * (c - 1));
            check($sformatf("busy_c%0d", c), busy1, c <= 8);
            check($sformatf("done_c%0d", c), done1, c == 9);
            if (extra > 0) check($sformatf("ovr_c%0d", c), ovr1, c > extra);
            if (c < 9) check_pos1($sformatf("hold_c%0d", c), old_mul);
            else begin
                check_pos1("commit", new_mul);
                check("valid_c9", valid1, 1'b1);
            end
        end
        if (!chain) begin
            tick();
            fs1 = 1'b0;
            check("done_c10", done1, 1'b0);
            check("busy_c10", busy1, 1'b0);
            check_pos1("after_c10", new_mul);
        end
    endtask

    initial begin
        reset = 1'b1;
        fs1 = 1'b0;
        fs2 = 1'b0;
        for (int k = 0; k < 6; k++) mem[k] = 16'(16'h0011 * (k + 1));
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state and long idle
        check("rst_addr", mif1.addr_a, 16'd6000);
        check("rst_flags", {busy1, done1, valid1, ovr1}, 4'b0000);
        check_pos1("rst_pos", 16'h0000);
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("idle", {mif1.addr_a, busy1, done1, valid1, ovr1,
                           pos1[0] | pos1[1] | pos1[2] | pos1[3] | pos1[4] | pos1[5]},
                  {16'd6000, 4'b0000, 16'h0000});
        end

        // basic fetch
        fs1 = 1'b1;
        run1(16'h0000, 16'h0011, 0, 1'b0);

        // frame_start while busy: overrun, single done, no restart
        fs1 = 1'b1;
        run1(16'h0011, 16'h0011, 4, 1'b0);
        tick();
        check("no_refetch_busy", busy1, 1'b0);
        check("ovr_sticky", ovr1, 1'b1);

        // back-to-back: second frame_start in the done cycle
        fs1 = 1'b1;
        run1(16'h0011, 16'h0011, 0, 1'b1);
        for (int k = 0; k < 6; k++) mem[k] = 16'(16'h0101 * (k + 1));
        run1(16'h0011, 16'h0101, 0, 1'b0);

        // reset mid-fetch aborts without commit
        fs1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            fs1 = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_flags", {busy1, done1, valid1, ovr1}, 4'b0000);
        check("abort_addr", mif1.addr_a, 16'd6000);
        check_pos1("abort_pos", 16'h0000);
        for (int c = 6; c <= 16; c++) begin
            tick();
            check($sformatf("abort_c%0d", c), {busy1, done1, valid1}, 3'b000);
        end

        // RD_LAT = 2
        fs2 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            fs2 = 1'b0;
            if (c <= 6) check($sformatf("l2_addr_c%0d", c), mif2.addr_a, 6000 + 4 * (c - 1));
            check($sformatf("l2_busy_c%0d", c), busy2, c <= 9);
            check($sformatf("l2_done_c%0d", c), done2, c == 10);
            for (int k = 0; k < 6; k++)
                check($sformatf("l2_pos%0d_c%0d", k, c), pos2[k],
                      (c >= 10) ? 16'(16'h0101 * (k + 1)) : 16'h0000);
        end
        check("l2_valid", valid2, 1'b1);
        check("l2_ovr", ovr2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
